// File: rtl/cp0_pkg.sv
// -----------------------------------------------------------------------------
// cp0_pkg
// Shared definitions for the coprocessor-0 register block: register indices,
// Status/Cause field positions, the interrupt ExcCode and the helpers that
// assemble the architectural read-back words from the stored fields.
// -----------------------------------------------------------------------------
package cp0_pkg;

    // CP0 register indices (rd field of mfc0/mtc0)
    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    // Status bit positions
    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LSB = 8;

    // Cause bit positions: IP[1:0] software, IP[6:2] hardware, IP[7] timer
    localparam int CAUSE_EXC_LSB   = 2;
    localparam int CAUSE_IP_SW_LSB = 8;
    localparam int CAUSE_IP_HW_LSB = 10;
    localparam int CAUSE_IP_TIMER  = 15;

    // ExcCode for an interrupt
    localparam logic [4:0] EXC_CODE_INT = 5'd0;

    // Writable/stored part of Status
    typedef struct packed {
        logic [7:0] im;
        logic       exl;
        logic       ie;
    } status_t;

    function automatic logic [31:0] status_pack(input status_t s);
        logic [31:0] w;
        w = '0;
        w[STATUS_IM_LSB +: 8] = s.im;
        w[STATUS_EXL]         = s.exl;
        w[STATUS_IE]          = s.ie;
        return w;
    endfunction

    function automatic logic [31:0] cause_pack(input logic       timer_pend,
                                               input logic [4:0] hw,
                                               input logic [1:0] sw);
        logic [31:0] w;
        w = '0;
        w[CAUSE_IP_TIMER]           = timer_pend;
        w[CAUSE_IP_HW_LSB +: 5]     = hw;
        w[CAUSE_IP_SW_LSB +: 2]     = sw;
        w[CAUSE_EXC_LSB +: 5]       = EXC_CODE_INT;
        return w;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// -----------------------------------------------------------------------------
// cp0_timer
// Count/Compare pair and the sticky timer-pending flag (Cause.IP[7]).
// Ports:
//   clk, clrn          clock, asynchronous active-low reset
//   wr_count           write wr_data into Count this cycle (beats increment)
//   wr_compare         write wr_data into Compare and clear timer_pend
//   wr_data            write data
//   count, compare     current register values
//   timer_pend         sticky match flag
// -----------------------------------------------------------------------------
module cp0_timer #(
    parameter bit COUNT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        wr_count,
    input  logic        wr_compare,
    input  logic [31:0] wr_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_pend
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        timer_pend_q, timer_pend_d;

    always_comb begin
        count_d      = count_q;
        compare_d    = compare_q;
        timer_pend_d = timer_pend_q;

        if (wr_count) begin
            count_d = wr_data;
        end else if (COUNT_EN) begin
            count_d = count_q + 32'd1;   // natural wrap at 2^32
        end

        // A Compare write acknowledges the timer; it takes priority over
        // a match occurring on the same edge.
        if (wr_compare) begin
            compare_d    = wr_data;
            timer_pend_d = 1'b0;
        end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
            timer_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            count_q      <= '0;
            compare_q    <= '0;
            timer_pend_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            compare_q    <= compare_d;
            timer_pend_q <= timer_pend_d;
        end
    end

    assign count      = count_q;
    assign compare    = compare_q;
    assign timer_pend = timer_pend_q;

endmodule

// File: rtl/cp0_regs.sv
// -----------------------------------------------------------------------------
// cp0_regs
// Coprocessor-0 register block: Count, Compare, Status, Cause, EPC.
// Handles mtc0 writes, mfc0 reads, interrupt sampling, interrupt entry
// (EXL set, EPC captured) and eret (EXL cleared).
// Ports:
//   clk, clrn                 clock, asynchronous active-low reset
//   mtc0/mtc0_rd/mtc0_data    CP0 register write
//   mfc0_rd/mfc0_src          combinational CP0 register read
//   int_req[4:0]              level interrupt lines -> Cause.IP[6:2]
//   inst_valid, epc_in        interrupt-stage instruction valid and its PC
//   eret                      exception return executing
//   intr, intr_pc             interrupt taken / redirect target
//   status_ie                 Status.IE
// -----------------------------------------------------------------------------
module cp0_regs
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0004,
    parameter bit          COUNT_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        mtc0,
    input  logic [4:0]  mtc0_rd,
    input  logic [31:0] mtc0_data,
    input  logic [4:0]  mfc0_rd,
    output logic [31:0] mfc0_src,
    input  logic [4:0]  int_req,
    input  logic        inst_valid,
    input  logic [31:0] epc_in,
    input  logic        eret,
    output logic        intr,
    output logic [31:0] intr_pc,
    output logic        status_ie
);

    status_t     status_q, status_d;
    logic [1:0]  cause_sw_q, cause_sw_d;
    logic [4:0]  cause_hw_q, cause_hw_d;
    logic [31:0] epc_q, epc_d;

    logic [31:0] count, compare;
    logic        timer_pend;
    logic [7:0]  ip;
    logic        pend;
    logic        wr_en;
    logic        wr_count, wr_compare;

    assign ip   = {timer_pend, cause_hw_q, cause_sw_q};
    assign pend = |(ip & status_q.im);
    assign intr = pend & status_q.ie & ~status_q.exl & inst_valid & ~eret;

    // The interrupted instruction will re-execute, so its mtc0 must not land.
    assign wr_en      = mtc0 & ~intr;
    assign wr_count   = wr_en && (mtc0_rd == CP0_COUNT);
    assign wr_compare = wr_en && (mtc0_rd == CP0_COMPARE);

    cp0_timer #(
        .COUNT_EN (COUNT_EN)
    ) u_timer (
        .clk        (clk),
        .clrn       (clrn),
        .wr_count   (wr_count),
        .wr_compare (wr_compare),
        .wr_data    (mtc0_data),
        .count      (count),
        .compare    (compare),
        .timer_pend (timer_pend)
    );

    always_comb begin
        status_d   = status_q;
        cause_sw_d = cause_sw_q;
        cause_hw_d = int_req;          // level sample, not sticky
        epc_d      = epc_q;

        if (wr_en) begin
            unique case (mtc0_rd)
                CP0_STATUS: begin
                    status_d.im  = mtc0_data[STATUS_IM_LSB +: 8];
                    status_d.exl = mtc0_data[STATUS_EXL];
                    status_d.ie  = mtc0_data[STATUS_IE];
                end
                CP0_CAUSE: cause_sw_d = mtc0_data[CAUSE_IP_SW_LSB +: 2];
                CP0_EPC:   epc_d      = mtc0_data;
                default: ;
            endcase
        end

        // intr already excludes eret, so these two never collide.
        if (intr) begin
            status_d.exl = 1'b1;
            epc_d        = epc_in;
        end else if (eret) begin
            status_d.exl = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            status_q   <= '0;
            cause_sw_q <= '0;
            cause_hw_q <= '0;
            epc_q      <= '0;
        end else begin
            status_q   <= status_d;
            cause_sw_q <= cause_sw_d;
            cause_hw_q <= cause_hw_d;
            epc_q      <= epc_d;
        end
    end

    // Read mux: no bypass of a same-cycle write.
    always_comb begin
        mfc0_src = '0;
        unique case (mfc0_rd)
            CP0_COUNT:   mfc0_src = count;
            CP0_COMPARE: mfc0_src = compare;
            CP0_STATUS:  mfc0_src = status_pack(status_q);
            CP0_CAUSE:   mfc0_src = cause_pack(timer_pend, cause_hw_q, cause_sw_q);
            CP0_EPC:     mfc0_src = epc_q;
            default:     mfc0_src = '0;
        endcase
    end

    assign intr_pc   = intr ? EXC_VECTOR : epc_q;
    assign status_ie = status_q.ie;

endmodule

// File: tb/tb_cp0_regs.sv
`timescale 1ns/100ps
module tb_cp0_regs;

    logic        clk = 1'b0;
    logic        clrn;
    logic        mtc0;
    logic [4:0]  mtc0_rd;
    logic [31:0] mtc0_data;
    logic [4:0]  mfc0_rd;
    logic [31:0] mfc0_src;
    logic [4:0]  int_req;
    logic        inst_valid;
    logic [31:0] epc_in;
    logic        eret;
    logic        intr;
    logic [31:0] intr_pc;
    logic        status_ie;

    int errors = 0;
    int checks = 0;

    always #10 clk = ~clk;

    cp0_regs #(
        .EXC_VECTOR (32'h0000_0004),
        .COUNT_EN   (1'b1)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .mtc0       (mtc0),
        .mtc0_rd    (mtc0_rd),
        .mtc0_data  (mtc0_data),
        .mfc0_rd    (mfc0_rd),
        .mfc0_src   (mfc0_src),
        .int_req    (int_req),
        .inst_valid (inst_valid),
        .epc_in     (epc_in),
        .eret       (eret),
        .intr       (intr),
        .intr_pc    (intr_pc),
        .status_ie  (status_ie)
    );

    typedef struct {
        logic        mtc0;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic [4:0]  rrd;
        logic [4:0]  irq;
        logic        iv;
        logic [31:0] epc;
        logic        er;
        logic        x_intr;
        logic [31:0] x_pc;
        logic [31:0] x_rd;
        logic        x_ie;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mtc0 = 1'b0; mtc0_rd = '0; mtc0_data = '0;
        int_req = '0; inst_valid = 1'b0; epc_in = '0; eret = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] rd, input logic [31:0] data);
        mtc0 = 1'b1; mtc0_rd = rd; mtc0_data = data;
        step();
        mtc0 = 1'b0;
    endtask

    function automatic vec_t mk(input logic m, input logic [4:0] wrd, input logic [31:0] wd,
                                input logic [4:0] rrd, input logic [4:0] irq, input logic iv,
                                input logic [31:0] epc, input logic er, input logic xi,
                                input logic [31:0] xpc, input logic [31:0] xrd, input logic xie);
        vec_t v;
        v.mtc0 = m; v.wrd = wrd; v.wdata = wd; v.rrd = rrd; v.irq = irq; v.iv = iv;
        v.epc = epc; v.er = er; v.x_intr = xi; v.x_pc = xpc; v.x_rd = xrd; v.x_ie = xie;
        return v;
    endfunction

    initial begin
        int k;
        logic [4:0] regs [5];
        logic seen;

        // Table: each row is one cycle; expectations reflect state before its edge.
        //            mtc0 wrd  wdata          rrd  irq iv epc     er  intr pc     rd             ie
        vecs[0]  = mk(1, 12, 32'hFFFF_FFFF, 12, 0, 0, 32'h0,  0,  0, 32'h0,  32'h0,        0);
        vecs[1]  = mk(1, 13, 32'hFFFF_FFFF, 12, 0, 0, 32'h0,  0,  0, 32'h0,  32'h0000_FF03, 1);
        vecs[2]  = mk(1, 12, 32'h0,         13, 0, 0, 32'h0,  0,  0, 32'h0,  32'h0000_0300, 1);
        vecs[3]  = mk(1, 13, 32'h0,         12, 0, 0, 32'h0,  0,  0, 32'h0,  32'h0,        0);
        vecs[4]  = mk(1, 12, 32'h401,       13, 0, 0, 32'h0,  0,  0, 32'h0,  32'h0,        0);
        vecs[5]  = mk(0, 0,  32'h0,         12, 1, 0, 32'h0,  0,  0, 32'h0,  32'h401,      1);
        vecs[6]  = mk(0, 0,  32'h0,         13, 1, 0, 32'h0,  0,  0, 32'h0,  32'h400,      1);
        vecs[7]  = mk(1, 14, 32'h1234,      14, 1, 1, 32'h40, 0,  1, 32'h4,  32'h0,        1);
        vecs[8]  = mk(0, 0,  32'h0,         14, 1, 1, 32'h0,  0,  0, 32'h40, 32'h40,       1);
        vecs[9]  = mk(0, 0,  32'h0,         12, 1, 1, 32'h0,  0,  0, 32'h40, 32'h403,      1);
        vecs[10] = mk(0, 0,  32'h0,         12, 1, 1, 32'h0,  1,  0, 32'h40, 32'h403,      1);
        vecs[11] = mk(0, 0,  32'h0,         12, 1, 1, 32'h80, 0,  1, 32'h4,  32'h401,      1);
        vecs[12] = mk(0, 0,  32'h0,         14, 0, 1, 32'h0,  1,  0, 32'h80, 32'h80,       1);
        vecs[13] = mk(1, 12, 32'h0,         12, 0, 0, 32'h0,  0,  0, 32'h80, 32'h401,      1);
        vecs[14] = mk(0, 0,  32'h0,         13, 0, 1, 32'h0,  1,  0, 32'h80, 32'h0,        0);
        vecs[15] = mk(1, 5,  32'hFFFF,      5,  0, 0, 32'h0,  0,  0, 32'h80, 32'h0,        0);
        vecs[16] = mk(0, 0,  32'h0,         5,  0, 0, 32'h0,  0,  0, 32'h80, 32'h0,        0);

        regs[0] = 5'd9; regs[1] = 5'd11; regs[2] = 5'd12; regs[3] = 5'd13; regs[4] = 5'd14;

        // Power-on reset
        clrn = 1'b0;
        idle_inputs();
        mfc0_rd = 5'd12;
        #2;
        chk("por_intr", {31'b0, intr}, 32'h0);
        chk("por_status_ie", {31'b0, status_ie}, 32'h0);
        chk("por_intr_pc", intr_pc, 32'h0);
        #3 clrn = 1'b1;
        step();

        // Table-driven single-cycle vectors
        for (int i = 0; i < NVEC; i++) begin
            mtc0 = vecs[i].mtc0; mtc0_rd = vecs[i].wrd; mtc0_data = vecs[i].wdata;
            mfc0_rd = vecs[i].rrd; int_req = vecs[i].irq; inst_valid = vecs[i].iv;
            epc_in = vecs[i].epc; eret = vecs[i].er;
            @(negedge clk);
            $display("vec %0d: rd=%0d src=%h intr=%b pc=%h ie=%b", i, mfc0_rd, mfc0_src, intr, intr_pc, status_ie);
            chk($sformatf("vec%0d_intr", i), {31'b0, intr}, {31'b0, vecs[i].x_intr});
            chk($sformatf("vec%0d_intr_pc", i), intr_pc, vecs[i].x_pc);
            chk($sformatf("vec%0d_mfc0", i), mfc0_src, vecs[i].x_rd);
            chk($sformatf("vec%0d_ie", i), {31'b0, status_ie}, {31'b0, vecs[i].x_ie});
            step();
        end
        idle_inputs();

        // Timer: Compare=10, Count=0, Status=IM7|IE; match 10 edges after the Status write
        wr(5'd11, 32'd10);
        wr(5'd9, 32'd0);
        wr(5'd12, 32'h0000_8001);
        inst_valid = 1'b1;
        epc_in = 32'h100;
        mfc0_rd = 5'd13;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            if (intr) seen = 1'b1;
            else begin
                step();
                k++;
            end
        end
        $display("timer: intr seen=%b after %0d edges cause=%h", seen, k, mfc0_src);
        chk("timer_fired", {31'b0, seen}, 32'h1);
        chk("timer_latency", k, 32'd10);
        chk("timer_cause", mfc0_src, 32'h0000_8000);
        chk("timer_intr_pc", intr_pc, 32'h4);
        step();
        inst_valid = 1'b0;
        wr(5'd11, 32'd20);
        @(negedge clk);
        $display("timer: cause after compare rewrite=%h", mfc0_src);
        chk("timer_clear", mfc0_src, 32'h0);
        step();

        // Count wrap
        wr(5'd9, 32'hFFFF_FFFF);
        mfc0_rd = 5'd9;
        @(negedge clk);
        $display("wrap: count=%h", mfc0_src);
        chk("count_max", mfc0_src, 32'hFFFF_FFFF);
        step();
        @(negedge clk);
        $display("wrap: count=%h", mfc0_src);
        chk("count_wrap", mfc0_src, 32'h0);
        step();

        // Compare write on the matching edge: clear wins over set
        wr(5'd11, 32'd101);
        wr(5'd9, 32'd100);
        step();
        wr(5'd11, 32'd101);
        mfc0_rd = 5'd13;
        @(negedge clk);
        $display("clear-wins: cause=%h", mfc0_src);
        chk("clear_wins", mfc0_src, 32'h0);
        step();

        // Asynchronous reset mid-cycle, checked without any clock edge
        #2 clrn = 1'b0;
        #1;
        for (int r = 0; r < 5; r++) begin
            mfc0_rd = regs[r];
            #1;
            $display("reset: reg %0d = %h", mfc0_rd, mfc0_src);
            chk($sformatf("rst_reg%0d", mfc0_rd), mfc0_src, 32'h0);
        end
        chk("rst_intr", {31'b0, intr}, 32'h0);
        chk("rst_status_ie", {31'b0, status_ie}, 32'h0);
        chk("rst_intr_pc", intr_pc, 32'h0);
        clrn = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
